// File: rtl/bank_cmd_issue_stage_if.sv
// Handshake bundle for bank_cmd_issue_stage.
//   Enqueue side : in_valid/in_ready, in_addr, in_data, in_cs/in_ras/in_cas/in_we
//   Issue side   : out_valid/out_ready, out_addr, out_data, out_cs/out_ras/out_cas/out_we,
//                  out_request_id
// master = scheduler/port environment, slave = the issue stage itself.
interface bank_cmd_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_cs;
  logic        in_ras;
  logic        in_cas;
  logic        in_we;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        out_cs;
  logic        out_ras;
  logic        out_cas;
  logic        out_we;
  logic [31:0] out_request_id;

  modport master (
    output in_valid, in_addr, in_data, in_cs, in_ras, in_cas, in_we, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_cs, out_ras, out_cas, out_we,
           out_request_id
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_cs, in_ras, in_cas, in_we, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_cs, out_ras, out_cas, out_we,
           out_request_id
  );
endinterface

// File: rtl/bank_cmd_issue_stage.sv
// bank_cmd_issue_stage
// Per-(rank,bank) DRAM command issue stage. Encoded commands are queued in a FIFO, tagged
// with a request id at enqueue, and the FIFO head is offered downstream only once its
// DRAM timing constraints (tRCD, tRAS, tRP, tRFC, tCCD) and the self-refresh state allow.
//
// Ports
//   clk           clock
//   reset         asynchronous reset, active-low; while low every output reads 0
//   bus           bank_cmd_issue_stage_if.slave (enqueue and issue handshakes)
//   global_cycle  free-running 64-bit cycle count
//   drop_count    saturating count of enqueue fires carrying an invalid encoding
//   stall_cycles  saturating count of cycles the head was held back or backpressured
//
// Build option
//   BANK_CMD_STALL_STATS_EN  when defined, stall_cycles counts; otherwise it is tied to 0.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_NORMAL | any head meeting its timers issues; SRE fire -> ST_SREF
// ST_SREF   | self refresh; only SRX may issue; SRX fire -> ST_NORMAL
module bank_cmd_issue_stage #(
  parameter int RANK  = 0,
  parameter int BANK  = 0,
  parameter int DEPTH = 8,
  parameter int T_RCD = 4,
  parameter int T_RAS = 8,
  parameter int T_RP  = 4,
  parameter int T_RFC = 16,
  parameter int T_CCD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  bank_cmd_issue_stage_if.slave bus,
  output logic [63:0]          global_cycle,
  output logic [15:0]          drop_count,
  output logic [31:0]          stall_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = 16;

  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_SRE = 4'b0000;
  localparam logic [3:0] CMD_SRX = 4'b0111;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_SREF   = 1'b1
  } state_t;

  state_t state;

  logic [31:0] mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [3:0]  mem_cmd  [DEPTH];
  logic [31:0] mem_id   [DEPTH];

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  logic          empty;
  logic          full;
  logic          code_ok;
  logic          head_elig;
  logic          in_fire;
  logic          enq;
  logic          deq;
  logic [3:0]    in_cmd;
  logic [3:0]    head_cmd;
  logic [31:0]   next_id;

  // Cycles remaining before the constrained command class may fire; 0 = satisfied.
  logic [TW-1:0] tmr_rcd;
  logic [TW-1:0] tmr_ras;
  logic [TW-1:0] tmr_rp;
  logic [TW-1:0] tmr_rfc;
  logic [TW-1:0] tmr_ccd;

  // RANK/BANK are informational; keep them referenced so they show up in netlists.
  logic [31:0] info_unused;
  assign info_unused = 32'(RANK) ^ 32'(BANK);

  assign wr_idx   = wr_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];
  assign in_cmd   = {bus.in_cs, bus.in_ras, bus.in_cas, bus.in_we};
  assign head_cmd = mem_cmd[rd_idx];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  always_comb begin
    code_ok = 1'b0;
    case (in_cmd)
      CMD_REF, CMD_PRE, CMD_ACT, CMD_RD, CMD_WR, CMD_SRE, CMD_SRX: code_ok = 1'b1;
      default: code_ok = 1'b0;
    endcase
  end

  always_comb begin
    head_elig = 1'b0;
    if (tmr_rfc == '0) begin
      if (state == ST_SREF) begin
        head_elig = (head_cmd == CMD_SRX);
      end else begin
        case (head_cmd)
          CMD_RD, CMD_WR:   head_elig = (tmr_rcd == '0) && (tmr_ccd == '0);
          CMD_PRE:          head_elig = (tmr_ras == '0);
          CMD_ACT, CMD_REF: head_elig = (tmr_rp == '0);
          CMD_SRE, CMD_SRX: head_elig = 1'b1;
          default:          head_elig = 1'b0;
        endcase
      end
    end
  end

  // Outputs are forced low while reset is held, including the FIFO read port.
  assign bus.in_ready       = reset && !full;
  assign bus.out_valid      = reset && !empty && head_elig;
  assign bus.out_addr       = reset ? mem_addr[rd_idx] : '0;
  assign bus.out_data       = reset ? mem_data[rd_idx] : '0;
  assign bus.out_request_id = reset ? mem_id[rd_idx] : '0;
  assign bus.out_cs         = reset && head_cmd[3];
  assign bus.out_ras        = reset && head_cmd[2];
  assign bus.out_cas        = reset && head_cmd[1];
  assign bus.out_we         = reset && head_cmd[0];

  assign in_fire = bus.in_valid && bus.in_ready;
  assign enq     = in_fire && code_ok;
  assign deq     = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_addr[wr_idx] <= bus.in_addr;
      mem_data[wr_idx] <= bus.in_data;
      mem_cmd[wr_idx]  <= in_cmd;
      mem_id[wr_idx]   <= next_id;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      next_id      <= '0;
      drop_count   <= '0;
      global_cycle <= '0;
    end else begin
      global_cycle <= global_cycle + 64'd1;
      if (enq) begin
        wr_ptr  <= wr_ptr + (AW+1)'(1);
        next_id <= next_id + 32'd1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (in_fire && !code_ok && (drop_count != '1)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  function automatic logic [TW-1:0] tick(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Loading T-1 at the end of fire cycle c makes the timer reach 0 in cycle c+T.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_rcd <= '0;
      tmr_ras <= '0;
      tmr_rp  <= '0;
      tmr_rfc <= '0;
      tmr_ccd <= '0;
    end else begin
      tmr_rcd <= tick(tmr_rcd);
      tmr_ras <= tick(tmr_ras);
      tmr_rp  <= tick(tmr_rp);
      tmr_rfc <= tick(tmr_rfc);
      tmr_ccd <= tick(tmr_ccd);
      if (deq) begin
        case (head_cmd)
          CMD_ACT: begin
            tmr_rcd <= TW'(T_RCD - 1);
            tmr_ras <= TW'(T_RAS - 1);
          end
          CMD_RD, CMD_WR:   tmr_ccd <= TW'(T_CCD - 1);
          CMD_PRE:          tmr_rp  <= TW'(T_RP - 1);
          CMD_REF, CMD_SRX: tmr_rfc <= TW'(T_RFC - 1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_NORMAL;
    end else if (deq) begin
      case (state)
        ST_NORMAL: if (head_cmd == CMD_SRE) state <= ST_SREF;
        ST_SREF:   if (head_cmd == CMD_SRX) state <= ST_NORMAL;
        default:   state <= ST_NORMAL;
      endcase
    end
  end

`ifdef BANK_CMD_STALL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (((!empty && !head_elig) || (bus.out_valid && !bus.out_ready)) &&
                 (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule
